pwm_comp_shadow_conv: RTL and testbench
=======================================

Name: pwm_comp_shadow_conv

Overview:
Converts per-unit signed duty commands from the current/voltage loop (AXI-Stream, one beat carries all channels) into center-aligned compare pairs for the PWM timer.
- Successor to the fixed-reload converter. Adds a runtime reload, signed Q1.x input, one shared multiplier sequenced by an FSM, saturation flags, and shadow registers.
- Shadow registers commit only on the timer's update event, so the compare pair never changes mid-period.
- Sits between the SVPWM/inverse-Park stage and the PWM counter block.

Parameters:
CH_NUM, 3, number of PWM channels
PWM_WIDTH, 16, width of reload and compare values (unsigned)
DATA_WIDTH, 16, width of each signed Q1.(DATA_WIDTH-1) duty word
DT_WIDTH, 8, deadtime input width (used only with PWM_DEADTIME_EN)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
s_axis_tdata  in  CH_NUM*DATA_WIDTH  duty words, channel i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat accepted when tvalid&&tready
reload  in  PWM_WIDTH  PWM period; sampled at beat accept
update_evt  in  1  one-cycle pulse from the PWM counter at period boundary
deadtime  in  DT_WIDTH  deadtime counts (PWM_DEADTIME_EN only)
comp1  out  CH_NUM*PWM_WIDTH  active compare values (shadow outputs)
comp2  out  CH_NUM*PWM_WIDTH  active compare values (shadow outputs)
sat  out  CH_NUM  per-channel saturation, committed with comp
pending  out  1  staged set waiting for update_evt

Behaviour:
- Reset (async assert, sync release):
  - FSM=IDLE; comp1, comp2, sat, pending, all staging registers = 0.
  - s_axis_tready = 0 while rstn is low.
- FSM states: IDLE, CALC, PEND.
  - s_axis_tready = 1 in IDLE and in PEND, 0 in CALC.
- IDLE:
  - On accept, latch tdata and reload (and deadtime); go to CALC with ch=0.
- CALC (one channel per cycle, CH_NUM cycles):
  - half = reload>>1 (PWM_WIDTH+1 bits, unsigned).
  - prod = d_ch (signed) * half (signed-extended).
  - off = prod >>> (DATA_WIDTH-1), arithmetic shift, floor rounding.
  - c1 = half - off, c2 = half + off, computed in a PWM_WIDTH+2-bit signed intermediate.
  - Clamp each of c1, c2 to [0, reload]. Set sat_stage[ch] if either value clamped.
  - Write stage1[ch], stage2[ch]; ch++.
  - After ch=CH_NUM-1: go to PEND, pending=1.
- Latency: beat accepted at cycle T; channel i staged at end of T+1+i; pending=1 from T+CH_NUM+1.
- PEND:
  - On update_evt: comp1/comp2/sat <= staging in one cycle, all channels simultaneously; pending=0; go to IDLE.
  - Accept without update_evt: discard staging and restart CALC (newest command wins). pending=0 until the new set completes.
  - update_evt and accept in the same cycle: commit the old staging first, then enter CALC with the new beat.
- update_evt outside PEND is ignored; comp holds. An event in the same cycle as the final CALC write does not commit; the set waits for the next event.
- Outputs change only on update_evt commit or reset.
- Boundary values:
  - reload=0: all outputs 0 with sat=0.
  - reload odd: half truncates; c2 is still clamped to reload.
  - d = most-negative (-1.0): c1=2*half, c2=0, not flagged as saturation.
- Reset asserted mid-CALC/PEND: staged data lost, outputs return to 0.

Optional Feature:
PWM_DEADTIME_EN
- Defined:
  - c1 = half - off - deadtime, c2 = half + off + deadtime, before clamp.
  - deadtime is latched at accept; clamps set sat.
- Undefined:
  - deadtime port is absent; formula as above without deadtime.

Test Plan:
- reload=5000, all d=0x0000, then update_evt → after commit comp1=comp2=2500 per channel, sat=0.
- reload=5000, d={0x4000,0xC000,0x0000} → comp1={1250,3750,2500}, comp2={3750,1250,2500}; comp unchanged until update_evt, pending high for 3+ cycles before.
- reload=5000, d=0x7FFF → off=2499, comp1=1, comp2=4999; d=0x8000 → comp1=5000, comp2=0, sat=0.
- Timing races:
  - Beat A staged (pending=1), beat B accepted with no event → after event outputs reflect B only.
  - update_evt coincident with accept of C in PEND → committed set is old staging; C commits on next event.
- PWM_DEADTIME_EN, reload=5000, deadtime=10, d=0x7FFF → comp1=0, comp2=5000, sat=1; d=0 → 2490/2510, sat=0.
- Assert rstn low during CALC → outputs 0, tready 0 immediately; after release tready=1, next beat processes normally.

Source files
------------

// File: rtl/pwm_comp_shadow_conv_if.sv
// rtl/pwm_comp_shadow_conv_if.sv - duty-command stream bundle for pwm_comp_shadow_conv
//
// Purpose: groups the AXI-Stream-like duty beat signals. One beat carries the
//          duty words of every channel.
// Signals:
//   tdata  - CH_NUM signed duty words, channel i at [(i+1)*DW-1 : i*DW]
//   tvalid - beat valid (driven by the producer)
//   tready - beat accepted when tvalid && tready (driven by the consumer)
// Modports: master (producer side), slave (consumer side).
interface pwm_comp_shadow_conv_if #(
  parameter int TDATA_WIDTH = 48
) ();
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tvalid;
  logic                   tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/pwm_comp_shadow_conv.sv
// rtl/pwm_comp_shadow_conv.sv - signed duty to shadowed center-aligned compare pair converter
//
// Purpose: converts per-unit signed Q1.(DATA_WIDTH-1) duty commands into
//          center-aligned compare pairs. One shared multiplier is stepped
//          through the channels, one channel per cycle. Results land in
//          staging registers and are committed to the outputs all at once
//          on the timer update event, so a compare pair never changes
//          mid-period.
// Optional feature: define PWM_DEADTIME_EN to add the deadtime port; the
//          deadtime value then widens the pair (c1 - dt, c2 + dt) before clamp.
// Ports:
//   clk        - clock
//   rstn       - asynchronous active-low reset
//   s_axis     - duty beat stream (slave modport: tdata, tvalid, tready)
//   reload     - PWM period, sampled when a beat is accepted
//   update_evt - one-cycle period-boundary pulse from the PWM counter
//   deadtime   - deadtime counts, sampled at accept (PWM_DEADTIME_EN only)
//   comp1      - active first compare values, channel i at [(i+1)*PW-1 : i*PW]
//   comp2      - active second compare values, same packing
//   sat        - per-channel saturation flag, committed together with comp
//   pending    - a complete staged set is waiting for update_evt
module pwm_comp_shadow_conv #(
  parameter int CH_NUM     = 3,
  parameter int PWM_WIDTH  = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DT_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rstn,
  pwm_comp_shadow_conv_if.slave         s_axis,
  input  logic [PWM_WIDTH-1:0]          reload,
  input  logic                          update_evt,
`ifdef PWM_DEADTIME_EN
  input  logic [DT_WIDTH-1:0]           deadtime,
`endif
  output logic [CH_NUM*PWM_WIDTH-1:0]   comp1,
  output logic [CH_NUM*PWM_WIDTH-1:0]   comp2,
  output logic [CH_NUM-1:0]             sat,
  output logic                          pending
);

  // Signed intermediate wide enough for half +/- off +/- deadtime without wrap.
  localparam int CW  = ((PWM_WIDTH > DT_WIDTH) ? PWM_WIDTH : DT_WIDTH) + 2;
  localparam int PRW = DATA_WIDTH + CW;
  localparam int IW  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                         tready_int;
  logic                         load;
  logic                         calc_we;
  logic                         calc_last;
  logic                         commit;

  logic [IW-1:0]                ch_q;
  logic signed [DATA_WIDTH-1:0] duty_q [CH_NUM];
  logic [PWM_WIDTH-1:0]         reload_q;
`ifdef PWM_DEADTIME_EN
  logic [DT_WIDTH-1:0]          dt_q;
`endif
  logic [PWM_WIDTH-1:0]         stage1_q [CH_NUM];
  logic [PWM_WIDTH-1:0]         stage2_q [CH_NUM];
  logic [CH_NUM-1:0]            sat_stage_q;

  logic signed [DATA_WIDTH-1:0] d_sel;
  logic signed [CW-1:0]         half_s;
  logic signed [CW-1:0]         rel_s;
  logic signed [CW-1:0]         off;
  logic signed [CW-1:0]         c1_raw;
  logic signed [CW-1:0]         c2_raw;
  logic signed [PRW-1:0]        prod;
  logic signed [PRW-1:0]        prod_sh;
  logic [PWM_WIDTH-1:0]         c1_val;
  logic [PWM_WIDTH-1:0]         c2_val;
  logic                         c1_sat;
  logic                         c2_sat;

  assign s_axis.tready = tready_int;
  assign calc_last     = (ch_q == IW'(CH_NUM - 1));

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tready_int = 1'b0;
    load       = 1'b0;
    calc_we    = 1'b0;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        // rstn gates tready so it reads 0 for the whole reset window.
        tready_int = rstn;
        if (s_axis.tvalid && rstn) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        calc_we = 1'b1;
        if (calc_last) begin
          state_d = PEND;
        end
      end
      PEND: begin
        tready_int = rstn;
        // Commit of the old set and acceptance of a new beat may coincide:
        // the outputs take the old staging, the new beat restarts CALC.
        commit = update_evt;
        if (s_axis.tvalid && rstn) begin
          load    = 1'b1;
          state_d = CALC;
        end else if (update_evt) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // Shared multiplier datapath, one channel per CALC cycle
  // ------------------------------------------------------------------
  assign d_sel   = duty_q[ch_q];
  assign half_s  = CW'({1'b0, reload_q[PWM_WIDTH-1:1]});
  assign rel_s   = CW'({1'b0, reload_q});
  assign prod    = PRW'(d_sel) * PRW'(half_s);
  // Arithmetic shift floors toward -inf, so d=-1.0 yields exactly -half.
  assign prod_sh = prod >>> (DATA_WIDTH - 1);
  assign off     = prod_sh[CW-1:0];

`ifdef PWM_DEADTIME_EN
  assign c1_raw = half_s - off - CW'(dt_q);
  assign c2_raw = half_s + off + CW'(dt_q);
`else
  assign c1_raw = half_s - off;
  assign c2_raw = half_s + off;
`endif

  always_comb begin
    c1_val = c1_raw[PWM_WIDTH-1:0];
    c1_sat = 1'b0;
    if (c1_raw[CW-1]) begin
      c1_val = '0;
      c1_sat = 1'b1;
    end else if (c1_raw > rel_s) begin
      c1_val = reload_q;
      c1_sat = 1'b1;
    end
  end

  always_comb begin
    c2_val = c2_raw[PWM_WIDTH-1:0];
    c2_sat = 1'b0;
    if (c2_raw[CW-1]) begin
      c2_val = '0;
      c2_sat = 1'b1;
    end else if (c2_raw > rel_s) begin
      c2_val = reload_q;
      c2_sat = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Latch, staging and shadow registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch_q        <= '0;
      reload_q    <= '0;
`ifdef PWM_DEADTIME_EN
      dt_q        <= '0;
`endif
      sat_stage_q <= '0;
      pending     <= 1'b0;
      comp1       <= '0;
      comp2       <= '0;
      sat         <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        duty_q[i]   <= '0;
        stage1_q[i] <= '0;
        stage2_q[i] <= '0;
      end
    end else begin
      if (commit) begin
        for (int i = 0; i < CH_NUM; i++) begin
          comp1[i*PWM_WIDTH +: PWM_WIDTH] <= stage1_q[i];
          comp2[i*PWM_WIDTH +: PWM_WIDTH] <= stage2_q[i];
        end
        sat <= sat_stage_q;
      end

      if (load) begin
        for (int i = 0; i < CH_NUM; i++) begin
          duty_q[i] <= s_axis.tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
        reload_q <= reload;
`ifdef PWM_DEADTIME_EN
        dt_q     <= deadtime;
`endif
        ch_q     <= '0;
      end else if (calc_we) begin
        stage1_q[ch_q]    <= c1_val;
        stage2_q[ch_q]    <= c2_val;
        sat_stage_q[ch_q] <= c1_sat | c2_sat;
        ch_q              <= ch_q + IW'(1);
      end

      if (calc_we && calc_last) begin
        pending <= 1'b1;
      end else if (load || commit) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_comp_shadow_conv.sv
// tb/tb_pwm_comp_shadow_conv.sv - self-checking bench for pwm_comp_shadow_conv
module tb_pwm_comp_shadow_conv;
  localparam int CH  = 3;
  localparam int PW  = 16;
  localparam int DW  = 16;
  localparam int DTW = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  pwm_comp_shadow_conv_if #(.TDATA_WIDTH(CH*DW)) s_axis ();
  logic [PW-1:0]    reload;
  logic             update_evt;
  logic [DTW-1:0]   deadtime;
  logic [CH*PW-1:0] comp1;
  logic [CH*PW-1:0] comp2;
  logic [CH-1:0]    sat;
  logic             pending;

  pwm_comp_shadow_conv #(
    .CH_NUM(CH), .PWM_WIDTH(PW), .DATA_WIDTH(DW), .DT_WIDTH(DTW)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_axis     (s_axis),
    .reload     (reload),
    .update_evt (update_evt),
`ifdef PWM_DEADTIME_EN
    .deadtime   (deadtime),
`endif
    .comp1      (comp1),
    .comp2      (comp2),
    .sat        (sat),
    .pending    (pending)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  // Behavioural model: a beat is busy for CH cycles, then its whole set sits
  // pending until an update event moves it to the outputs.
  int m_busy;
  bit m_pend;
  int st1 [CH];
  int st2 [CH];
  bit sts [CH];
  int mc1 [CH];
  int mc2 [CH];
  bit ms  [CH];

  int cur_rl;
  int cur_dt;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic longint floor_div(input longint num, input longint den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  function automatic void ref_calc(input int d, input int rl, input int dt,
                                   output int c1, output int c2, output bit s);
    int half;
    longint off;
    half = rl / 2;
    off  = floor_div(longint'(d) * half, 32768);
    c1   = half - int'(off) - dt;
    c2   = half + int'(off) + dt;
    s    = 0;
    if (c1 < 0)  begin c1 = 0;  s = 1; end
    if (c1 > rl) begin c1 = rl; s = 1; end
    if (c2 < 0)  begin c2 = 0;  s = 1; end
    if (c2 > rl) begin c2 = rl; s = 1; end
  endfunction

  task automatic mreset();
    m_busy = 0;
    m_pend = 0;
    for (int i = 0; i < CH; i++) begin
      st1[i] = 0; st2[i] = 0; sts[i] = 0;
      mc1[i] = 0; mc2[i] = 0; ms[i] = 0;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("comp1[%0d]", i), longint'(comp1[i*PW +: PW]), longint'(mc1[i]));
      chk($sformatf("comp2[%0d]", i), longint'(comp2[i*PW +: PW]), longint'(mc2[i]));
      chk($sformatf("sat[%0d]", i), longint'(sat[i]), longint'(ms[i]));
    end
    chk("pending", longint'(pending), longint'(m_pend));
    chk("tready", longint'(s_axis.tready), longint'(rstn && (m_busy == 0)));
  endtask

  always @(posedge clk) begin
    if (chk_en) begin
      #2;
      compare_all();
    end
  end

  // One cycle: drive inputs at a falling edge, advance the model across the
  // coming rising edge, return at the next falling edge.
  task automatic drive(input logic v, input logic [CH*DW-1:0] dat, input logic evt);
    bit acc;
    int dv, dt;
    s_axis.tvalid = v;
    s_axis.tdata  = dat;
    reload        = PW'(cur_rl);
    deadtime      = DTW'(cur_dt);
    update_evt    = evt;
`ifdef PWM_DEADTIME_EN
    dt = cur_dt;
`else
    dt = 0;
`endif
    acc = v && (m_busy == 0);
    if (m_pend && evt) begin
      for (int i = 0; i < CH; i++) begin
        mc1[i] = st1[i]; mc2[i] = st2[i]; ms[i] = sts[i];
      end
      m_pend = 0;
    end
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_pend = 1;
    end
    if (acc) begin
      for (int i = 0; i < CH; i++) begin
        dv = int'($signed(dat[i*DW +: DW]));
        ref_calc(dv, cur_rl, dt, st1[i], st2[i], sts[i]);
      end
      m_busy = CH;
      m_pend = 0;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, '0, 1'b0);
  endtask

  task automatic event_cycle();
    drive(1'b0, '0, 1'b1);
  endtask

  task automatic lit(input string nm, input int ch, input int e1, input int e2, input int es);
    chk({nm, "_c1"}, longint'(comp1[ch*PW +: PW]), longint'(e1));
    chk({nm, "_c2"}, longint'(comp2[ch*PW +: PW]), longint'(e2));
    chk({nm, "_sat"}, longint'(sat[ch]), longint'(es));
  endtask

  function automatic logic [CH*DW-1:0] rand_beat();
    logic [CH*DW-1:0] b;
    int sel;
    for (int i = 0; i < CH; i++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       b[i*DW +: DW] = 16'h7FFF;
        1:       b[i*DW +: DW] = 16'h8000;
        2:       b[i*DW +: DW] = 16'h0000;
        default: b[i*DW +: DW] = DW'($urandom());
      endcase
    end
    return b;
  endfunction

  initial begin
    int a1, a2;
    bit as;

    // Model pins, hand-computed.
    ref_calc(32767, 5000, 0, a1, a2, as);
    chk("pin_7fff_c1", a1, 1);    chk("pin_7fff_c2", a2, 4999); chk("pin_7fff_s", as, 0);
    ref_calc(-32768, 5000, 0, a1, a2, as);
    chk("pin_8000_c1", a1, 5000); chk("pin_8000_c2", a2, 0);    chk("pin_8000_s", as, 0);
    ref_calc(16384, 5000, 0, a1, a2, as);
    chk("pin_4000_c1", a1, 1250); chk("pin_4000_c2", a2, 3750);
    ref_calc(-32768, 4001, 0, a1, a2, as);
    chk("pin_odd_c1", a1, 4000);  chk("pin_odd_c2", a2, 0);
    ref_calc(32767, 5000, 10, a1, a2, as);
    chk("pin_dt_c1", a1, 0);      chk("pin_dt_c2", a2, 5000);   chk("pin_dt_s", as, 1);

    rstn = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    reload = '0;
    update_evt = 1'b0;
    deadtime = '0;
    cur_rl = 5000;
    cur_dt = 0;
    mreset();
    chk_en = 1;
    repeat (3) @(negedge clk);
    chk("rst_tready", s_axis.tready, 0);
    lit("rst", 0, 0, 0, 0);
    rstn = 1'b1;

    // All zero duty.
    drive(1'b1, '0, 1'b0);
    idle(4);
    event_cycle();
    for (int i = 0; i < CH; i++) lit("zero", i, 2500, 2500, 0);

    // Mixed duty, pending held several cycles before the event.
    drive(1'b1, {16'h0000, 16'hC000, 16'h4000}, 1'b0);
    idle(6);
    chk("mix_pending", pending, 1);
    lit("mix_hold", 0, 2500, 2500, 0);
    event_cycle();
    lit("mix0", 0, 1250, 3750, 0);
    lit("mix1", 1, 3750, 1250, 0);
    lit("mix2", 2, 2500, 2500, 0);

    // Full-scale positive and negative.
    drive(1'b1, {16'h0000, 16'h8000, 16'h7FFF}, 1'b0);
    idle(4);
    event_cycle();
    lit("fs_pos", 0, 1, 4999, 0);
    lit("fs_neg", 1, 5000, 0, 0);

    // Newest command wins while pending.
    drive(1'b1, {3{16'h4000}}, 1'b0);
    idle(4);
    drive(1'b1, {3{16'hC000}}, 1'b0);
    idle(4);
    event_cycle();
    lit("race_b", 0, 3750, 1250, 0);

    // Event coincident with a new accept commits the old set.
    drive(1'b1, {3{16'h0000}}, 1'b0);
    idle(4);
    drive(1'b1, {3{16'h4000}}, 1'b1);
    lit("coinc_old", 0, 2500, 2500, 0);
    chk("coinc_tready", s_axis.tready, 0);
    idle(4);
    event_cycle();
    lit("coinc_new", 0, 1250, 3750, 0);

    // Event in the same cycle as the last CALC write must not commit.
    drive(1'b1, {3{16'h0000}}, 1'b0);
    idle(2);
    event_cycle();
    chk("late_pending", pending, 1);
    lit("late_hold", 0, 1250, 3750, 0);
    event_cycle();
    lit("late_commit", 0, 2500, 2500, 0);

    // Odd reload and zero reload.
    cur_rl = 4001;
    drive(1'b1, {16'h0000, 16'h8000, 16'h7FFF}, 1'b0);
    idle(4);
    event_cycle();
    lit("odd0", 0, 1, 3999, 0);
    lit("odd1", 1, 4000, 0, 0);
    cur_rl = 0;
    drive(1'b1, {16'h0000, 16'h8000, 16'h7FFF}, 1'b0);
    idle(4);
    event_cycle();
`ifndef PWM_DEADTIME_EN
    lit("rl0", 0, 0, 0, 0);
    lit("rl0n", 1, 0, 0, 0);
`endif

`ifdef PWM_DEADTIME_EN
    cur_rl = 5000;
    cur_dt = 10;
    drive(1'b1, {16'h0000, 16'h0000, 16'h7FFF}, 1'b0);
    idle(4);
    event_cycle();
    lit("dt_fs", 0, 0, 5000, 1);
    lit("dt_zero", 1, 2490, 2510, 0);
    cur_dt = 0;
`endif

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      cur_rl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 65535));
`ifdef PWM_DEADTIME_EN
      cur_dt = int'($urandom_range(0, 255));
`endif
      drive(($urandom_range(0, 2) == 0), rand_beat(), ($urandom_range(0, 3) == 0));
    end
    idle(4);
    event_cycle();

    // Reset in the middle of CALC.
    cur_rl = 5000;
    cur_dt = 0;
    drive(1'b1, {3{16'h4000}}, 1'b0);
    drive(1'b0, '0, 1'b0);
    rstn = 1'b0;
    #1;
    chk("midrst_tready", s_axis.tready, 0);
    chk("midrst_pending", pending, 0);
    lit("midrst", 0, 0, 0, 0);
    mreset();
    @(negedge clk);
    rstn = 1'b1;
    drive(1'b1, {3{16'h0000}}, 1'b0);
    idle(4);
    event_cycle();
    lit("post_rst", 0, 2500, 2500, 0);

    chk_en = 0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
